// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: shared constants, register map and scan state encoding for the
// 4-digit multiplexed 7-segment display controller.
package hex_disp_pkg;
    // Entry n is the segment pattern for nibble n; bit 2 is the decimal point.
    localparam logic [15:0][7:0] SEG_MAP = {
        8'hD1, 8'hD3, 8'h3B, 8'hC3, 8'h5B, 8'hF9, 8'hFA, 8'hFB,
        8'hA8, 8'hDB, 8'hDA, 8'h78, 8'hBA, 8'hB3, 8'h28, 8'hEB
    };
    localparam int DP_BIT = 2;
    localparam int CTRL_DP_LSB = 4;
    localparam int CTRL_BRT_LSB = 8;
    localparam int CTRL_GEN_BIT = 16;
    localparam logic [31:0] CTRL_MASK = 32'h0001_0FFF;
    localparam logic [31:0] CTRL_RST = 32'h0001_0F0F;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_LIT = 2'd2;
    typedef enum logic [1:0] {
        REG_VALUE = 2'd0,
        REG_CTRL = 2'd1,
        REG_STATUS = 2'd2,
        REG_NONE = 2'd3
    } reg_e;
endpackage

// File: rtl/hex_disp_scan.sv
// hex_disp_scan: digit scan FSM with blanking dead time, brightness phases and
// frame-aligned shadow copies of the displayed value and control fields.
module hex_disp_scan
    import hex_disp_pkg::*;
#(
    parameter int SCAN_DIV = 100_000,
    parameter int BLANK_CYCLES = 1_024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [11:0] ctrl,
    input  logic        gen_en,
    output logic [7:0]  hex_out,
    output logic [3:0]  sel,
    output logic [3:0]  status
);
    localparam int PHASE = (SCAN_DIV - BLANK_CYCLES) / 16;
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam int PW = $clog2(PHASE + 1);

    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= SCAN_DIV || (SCAN_DIV - BLANK_CYCLES) % 16 != 0) begin : g_bad_params
        $error("hex_disp_scan: need 1 <= BLANK_CYCLES < SCAN_DIV and (SCAN_DIV-BLANK_CYCLES) divisible by 16");
    end

    logic [1:0]    state, nstate, digit, ndigit;
    logic [BW-1:0] bcnt, nbcnt;
    logic [PW-1:0] pcnt, npcnt;
    logic [3:0]    phase, nphase, nsel;
    logic [15:0]   sh_value, nsh_value;
    logic [11:0]   sh_ctrl, nsh_ctrl;
    logic [7:0]    nhex;
    logic          load, last_blank, last_pcnt, drive;

    always_comb begin
        last_blank = bcnt == BW'(BLANK_CYCLES - 1);
        last_pcnt = pcnt == PW'(PHASE - 1);
        nstate = state;
        ndigit = digit;
        nbcnt = '0;
        npcnt = '0;
        nphase = '0;
        load = 1'b0;
        if (!gen_en) begin
            nstate = ST_IDLE;
            ndigit = '0;
        end else if (state == ST_IDLE) begin
            nstate = ST_BLANK;
            ndigit = '0;
            load = 1'b1;
        end else if (state == ST_BLANK) begin
            nstate = last_blank ? ST_LIT : ST_BLANK;
            nbcnt = last_blank ? '0 : bcnt + 1'b1;
        end else begin
            npcnt = last_pcnt ? '0 : pcnt + 1'b1;
            nphase = last_pcnt ? phase + 1'b1 : phase;
            if (last_pcnt && phase == 4'hF) begin
                nstate = ST_BLANK;
                ndigit = digit + 1'b1;
                load = digit == 2'd3;
            end
        end
        // Outputs are computed from next state so the pins line up with the state registers.
        nsh_value = load ? value : sh_value;
        nsh_ctrl = load ? ctrl : sh_ctrl;
        drive = nstate == ST_LIT && nsh_ctrl[ndigit] && nphase <= nsh_ctrl[CTRL_BRT_LSB +: 4];
        nhex = drive ? SEG_MAP[nsh_value[{ndigit, 2'b00} +: 4]] | (8'(nsh_ctrl[CTRL_DP_LSB + ndigit]) << DP_BIT) : 8'h00;
        nsel = drive ? ~(4'b0001 << ndigit) : 4'hF;
        status = {state == ST_BLANK, state == ST_LIT, digit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BLANK;
            digit <= '0;
            bcnt <= '0;
            pcnt <= '0;
            phase <= '0;
            sh_value <= '0;
            sh_ctrl <= CTRL_RST[11:0];
            hex_out <= 8'h00;
            sel <= 4'hF;
        end else begin
            state <= nstate;
            digit <= ndigit;
            bcnt <= nbcnt;
            pcnt <= npcnt;
            phase <= nphase;
            sh_value <= nsh_value;
            sh_ctrl <= nsh_ctrl;
            hex_out <= nhex;
            sel <= nsel;
        end
    end
endmodule

// File: rtl/hex_disp_ctrl.sv
// hex_disp_ctrl: bus-attached VALUE/CTRL/STATUS registers driving the 7-segment
// scan engine.
module hex_disp_ctrl
    import hex_disp_pkg::*;
#(
    parameter int SCAN_DIV = 100_000,
    parameter int BLANK_CYCLES = 1_024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [7:0]  hex_out,
    output logic [3:0]  sel
);
    logic [31:0] value, ctrl, wmask, rd_mux;
    logic [3:0]  status;
    logic        unused_addr;
    reg_e        rsel;

    always_comb begin
        rsel = reg_e'(addr_i[3:2]);
        unused_addr = ^addr_i[1:0];
        wmask = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
        rd_mux = rsel == REG_VALUE ? value :
                 rsel == REG_CTRL ? ctrl :
                 rsel == REG_STATUS ? {28'd0, status} : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            ctrl <= CTRL_RST;
            rvalid_o <= 1'b0;
            rdata_o <= '0;
        end else begin
            rvalid_o <= req_i;
            rdata_o <= (req_i && !we_i) ? rd_mux : '0;
            if (req_i && we_i && rsel == REG_VALUE)
                value <= (value & ~wmask) | (wdata_i & wmask);
            if (req_i && we_i && rsel == REG_CTRL)
                ctrl <= ((ctrl & ~wmask) | (wdata_i & wmask)) & CTRL_MASK;
        end
    end

    hex_disp_scan #(
        .SCAN_DIV(SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_scan (
        .clk(clk),
        .rst(rst),
        .value(value[15:0]),
        .ctrl(ctrl[11:0]),
        .gen_en(ctrl[CTRL_GEN_BIT]),
        .hex_out(hex_out),
        .sel(sel),
        .status(status)
    );
endmodule

// File: tb/tb_hex_disp_ctrl.sv
// tb_hex_disp_ctrl: register table, directed display sequences and random bus
// traffic, all checked every cycle against a frame-position reference model.
module tb_hex_disp_ctrl;
    localparam int SD = 80;
    localparam int BL = 16;
    localparam int PH = (SD - BL) / 16;
    localparam int FR = 4 * SD;

    logic        clk = 0, rst = 1, req = 0, we = 0;
    logic [3:0]  be = 0, addr = 0;
    logic [31:0] wdata = 0, rdata;
    logic        rvalid;
    logic [7:0]  hex_out;
    logic [3:0]  sel;

    hex_disp_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .hex_out(hex_out), .sel(sel)
    );

    always #5 clk = ~clk;

    logic [7:0] seg_ref [16] = '{8'hEB, 8'h28, 8'hB3, 8'hBA, 8'h78, 8'hDA, 8'hDB, 8'hA8,
                                 8'hFB, 8'hFA, 8'hF9, 8'h5B, 8'hC3, 8'h3B, 8'hD3, 8'hD1};

    int n_chk = 0, n_fail = 0;
    // Model: pos is cycles since the current frame started, -1 while disabled.
    int pos;
    logic [31:0] m_val, m_ctrl, sh_val, sh_ctrl, e_rdata;
    logic        e_rvalid;
    logic [3:0][7:0] mcnt, mhx;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t pos=%0d)", nm, act, exp, $time, pos);
        end
    endtask

    task automatic model_reset();
        pos = 0;
        m_val = 0;
        m_ctrl = 32'h0001_0F0F;
        sh_val = m_val;
        sh_ctrl = m_ctrl;
    endtask

    function automatic logic [3:0] m_status(int p);
        int off;
        if (p < 0) return 4'h0;
        off = p % SD;
        return {off < BL, off >= BL, 2'(p / SD)};
    endfunction

    function automatic logic [31:0] m_read(logic [3:0] a);
        case (a[3:2])
            2'd0: return m_val;
            2'd1: return m_ctrl;
            2'd2: return {28'd0, m_status(pos)};
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_drive(int p);
        int slot, off;
        if (p < 0) return 0;
        slot = p / SD;
        off = p % SD;
        return off >= BL && (off - BL) / PH <= int'(sh_ctrl[11:8]) && sh_ctrl[slot];
    endfunction

    function automatic logic [7:0] m_hex(int p);
        int slot;
        if (!m_drive(p)) return 8'h00;
        slot = p / SD;
        return seg_ref[sh_val[slot*4 +: 4]] | (sh_ctrl[4+slot] ? 8'h04 : 8'h00);
    endfunction

    function automatic logic [3:0] m_sel(int p);
        logic [3:0] s;
        if (!m_drive(p)) return 4'hF;
        s = 4'hF;
        s[p / SD] = 1'b0;
        return s;
    endfunction

    task automatic step(input logic r, input logic w, input logic [3:0] b, input logic [3:0] a, input logic [31:0] d);
        logic [31:0] m;
        req = r; we = w; be = b; addr = a; wdata = d;
        @(posedge clk);
        e_rvalid = r;
        e_rdata = (r && !w) ? m_read(a) : 32'd0;
        if (!m_ctrl[16]) pos = -1;
        else if (pos < 0 || pos == FR - 1) begin
            pos = 0;
            sh_val = m_val;
            sh_ctrl = m_ctrl;
        end else pos++;
        m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        if (r && w && a[3:2] == 2'd0) m_val = (m_val & ~m) | (d & m);
        if (r && w && a[3:2] == 2'd1) m_ctrl = ((m_ctrl & ~m) | (d & m)) & 32'h0001_0FFF;
        #1;
        chk("hex", {24'd0, hex_out}, {24'd0, m_hex(pos)});
        chk("sel", {28'd0, sel}, {28'd0, m_sel(pos)});
        chk("rvalid", {31'd0, rvalid}, {31'd0, e_rvalid});
        chk("rdata", rdata, e_rdata);
        req = 0; we = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 4'h0, 4'h0, 32'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        step(1, 1, 4'hF, a, d);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1, 0, 4'h0, a, 32'd0);
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (pos != p && n < FR + 2) begin
            idle(1);
            n++;
        end
        if (pos != p) begin
            n_chk++; n_fail++;
            $display("FAIL wait_pos: got pos %0d expected %0d", pos, p);
        end
    endtask

    task automatic sync_frame();
        idle(1);
        wait_pos(0);
    endtask

    task automatic measure();
        mcnt = '0;
        mhx = '0;
        for (int i = 0; i < FR - 1; i++) begin
            idle(1);
            for (int d = 0; d < 4; d++)
                if (sel == ~(4'b0001 << d)) begin
                    mcnt[d] = mcnt[d] + 8'd1;
                    mhx[d] = hex_out;
                end
        end
    endtask

    task automatic frame_chk(input string tag, input logic [3:0][7:0] ec, input logic [3:0][7:0] eh);
        measure();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s_cnt%0d", tag, d), {24'd0, mcnt[d]}, {24'd0, ec[d]});
            chk($sformatf("%s_hex%0d", tag, d), {24'd0, mhx[d]}, {24'd0, eh[d]});
        end
    endtask

    initial begin
        int n;
        logic [3:0] psel;
        logic [3:0] a;
        logic [31:0] d;
        tbl[0]  = '{1'b1, 4'hF, 4'h0, 32'h1234_5678, 32'h0};
        tbl[1]  = '{1'b0, 4'h0, 4'h0, 32'h0,         32'h1234_5678};
        tbl[2]  = '{1'b1, 4'h5, 4'h1, 32'hAABB_CCDD, 32'h0};
        tbl[3]  = '{1'b0, 4'h0, 4'h3, 32'h0,         32'h12BB_56DD};
        tbl[4]  = '{1'b1, 4'hF, 4'h4, 32'hFFFF_FFFF, 32'h0};
        tbl[5]  = '{1'b0, 4'h0, 4'h4, 32'h0,         32'h0001_0FFF};
        tbl[6]  = '{1'b1, 4'h2, 4'h6, 32'h0,         32'h0};
        tbl[7]  = '{1'b0, 4'h0, 4'h4, 32'h0,         32'h0001_00FF};
        tbl[8]  = '{1'b1, 4'hF, 4'hC, 32'hFFFF_FFFF, 32'h0};
        tbl[9]  = '{1'b0, 4'h0, 4'hC, 32'h0,         32'h0};
        tbl[10] = '{1'b0, 4'h0, 4'h0, 32'h0,         32'h12BB_56DD};
        tbl[11] = '{1'b1, 4'hF, 4'h4, 32'h0001_0F0F, 32'h0};
        tbl[12] = '{1'b0, 4'h0, 4'h4, 32'h0,         32'h0001_0F0F};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hex", {24'd0, hex_out}, 32'h0);
        chk("rst_sel", {28'd0, sel}, 32'hF);
        chk("rst_rvalid", {31'd0, rvalid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 0;

        idle(BL - 1);
        chk("first_blank_sel", {28'd0, sel}, 32'hF);
        idle(1);
        chk("first_lit_sel", {28'd0, sel}, 32'hE);
        chk("first_lit_hex", {24'd0, hex_out}, 32'hEB);
        n = 0;
        psel = sel;
        do begin
            psel = sel;
            idle(1);
            n++;
        end while (!(sel == 4'hE && psel != 4'hE) && n < 2 * FR);
        chk("frame_len", n, FR);

        for (int i = 0; i < 13; i++) begin
            step(1, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata);
            chk($sformatf("tbl%0d", i), rdata, tbl[i].exp);
        end

        wr(4'h0, 32'h0000_A5F3);
        wr(4'h4, 32'h0001_0F0F);
        sync_frame();
        frame_chk("a5f3", {8'd64, 8'd64, 8'd64, 8'd64}, {8'hF9, 8'hDA, 8'hD1, 8'hBA});
        wr(4'h4, 32'h0001_030F);
        sync_frame();
        frame_chk("b3", {8'd16, 8'd16, 8'd16, 8'd16}, {8'hF9, 8'hDA, 8'hD1, 8'hBA});
        wr(4'h4, 32'h0001_000F);
        sync_frame();
        frame_chk("b0", {8'd4, 8'd4, 8'd4, 8'd4}, {8'hF9, 8'hDA, 8'hD1, 8'hBA});
        wr(4'h4, 32'h0001_0F15);
        sync_frame();
        frame_chk("en5dp1", {8'd0, 8'd64, 8'd0, 8'd64}, {8'h00, 8'hDA, 8'h00, 8'hBE});

        wr(4'h4, 32'h0001_0F0F);
        sync_frame();
        wait_pos(FR - 1);
        wr(4'h0, 32'h0000_1234);
        frame_chk("bnd_old", {8'd64, 8'd64, 8'd64, 8'd64}, {8'hF9, 8'hDA, 8'hD1, 8'hBA});
        sync_frame();
        frame_chk("bnd_new", {8'd64, 8'd64, 8'd64, 8'd64}, {8'h28, 8'hB3, 8'hBA, 8'h78});
        sync_frame();
        idle(100);
        wr(4'h0, 32'h0000_8888);
        sync_frame();
        frame_chk("mid_new", {8'd64, 8'd64, 8'd64, 8'd64}, {8'hFB, 8'hFB, 8'hFB, 8'hFB});

        wait_pos(SD + BL + 3);
        rd(4'h8);
        chk("status_lit1", rdata, 32'h5);
        wait_pos(2 * SD + 2);
        rd(4'h8);
        chk("status_blank2", rdata, 32'hA);

        wait_pos(BL + 5);
        wr(4'h4, 32'h0000_0F0F);
        chk("dis_still_lit", {28'd0, sel}, 32'hE);
        idle(1);
        chk("dis_idle_sel", {28'd0, sel}, 32'hF);
        chk("dis_idle_hex", {24'd0, hex_out}, 32'h0);
        rd(4'h8);
        chk("dis_status", rdata, 32'h0);
        wr(4'h4, 32'h0001_0F0F);
        idle(BL + 4);

        wait_pos(SD + 40);
        rd(4'h0);
        rst = 1;
        #1;
        chk("midrst_hex", {24'd0, hex_out}, 32'h0);
        chk("midrst_sel", {28'd0, sel}, 32'hF);
        chk("midrst_rvalid", {31'd0, rvalid}, 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 0;
        model_reset();
        rd(4'h0);
        chk("midrst_value", rdata, 32'h0);
        rd(4'h4);
        chk("midrst_ctrl", rdata, 32'h0001_0F0F);

        for (int i = 0; i < 2500; i++) begin
            a = 4'($urandom);
            d = $urandom;
            if (a[3:2] == 2'd1) d[16] = ($urandom % 8) != 0;
            step(($urandom % 3) == 0, $urandom % 2 == 1, 4'($urandom), a, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
